// File: rtl/shift_window_pkg.sv
// rtl/shift_window_pkg.sv - mode encodings and width helpers for shift_window
package shift_window_pkg;

    localparam logic [1:0] MODE_SHIFT  = 2'b00;
    localparam logic [1:0] MODE_LOAD   = 2'b01;
    localparam logic [1:0] MODE_ROTATE = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_LENGTH = 4;

    // Returns 0 for n <= 1, so callers must guarantee a non-zero result where a width is needed.
    function automatic int sw_clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int count_w(input int length);
        return sw_clog2(length + 1);
    endfunction

    function automatic int sum_w(input int width, input int length);
        return width + sw_clog2(length);
    endfunction

    localparam int DEF_COUNT_W = count_w(DEF_LENGTH);
    localparam int DEF_SUM_W   = sum_w(DEF_WIDTH, DEF_LENGTH);

endpackage

// File: rtl/shift_window_acc.sv
// rtl/shift_window_acc.sv - running window-sum register (add newest, subtract evicted)
module shift_window_acc
    import shift_window_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SUM_W = DEF_SUM_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [SUM_W-1:0] i_load_val,
    input  logic             i_upd,
    input  logic [WIDTH-1:0] i_add,
    input  logic [WIDTH-1:0] i_sub,
    output logic [SUM_W-1:0] o_sum
);

    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] sum_d;

    // The evicted word is always part of the current sum, so the subtraction never wraps.
    always_comb begin
        sum_d = sum_q;
        if (i_clr) begin
            sum_d = '0;
        end else if (i_load) begin
            sum_d = i_load_val;
        end else if (i_upd) begin
            sum_d = sum_q + SUM_W'(i_add) - SUM_W'(i_sub);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign o_sum = sum_q;

endmodule

// File: rtl/shift_window.sv
// rtl/shift_window.sv - sample-window shift register; running sum built under SHIFT_WINDOW_SUM_EN
module shift_window
    import shift_window_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LENGTH = DEF_LENGTH
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_en,
    input  logic                              i_clr,
    input  logic [1:0]                        i_mode,
    input  logic                              i_valid,
    input  logic [WIDTH-1:0]                  i_data,
    input  logic [WIDTH*LENGTH-1:0]           i_load,
    input  logic [sw_clog2(LENGTH)-1:0]       i_tap_sel,
    output logic [WIDTH-1:0]                  o_ser,
    output logic [WIDTH*LENGTH-1:0]           o_par,
    output logic [WIDTH-1:0]                  o_tap,
    output logic [count_w(LENGTH)-1:0]        o_count,
    output logic                              o_full,
    output logic                              o_valid,
    output logic [sum_w(WIDTH, LENGTH)-1:0]   o_sum
);

    localparam int TAP_W = sw_clog2(LENGTH);
    localparam int CNT_W = count_w(LENGTH);
    localparam int SUM_W = sum_w(WIDTH, LENGTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LENGTH);

    logic [WIDTH-1:0] stage_q [LENGTH];
    logic [WIDTH-1:0] stage_d [LENGTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             valid_q;
    logic             valid_d;

    always_comb begin
        stage_d = stage_q;
        count_d = count_q;
        valid_d = 1'b0;
        if (i_en) begin
            if (i_clr) begin
                for (int k = 0; k < LENGTH; k++) begin
                    stage_d[k] = '0;
                end
                count_d = '0;
            end else begin
                case (i_mode)
                    MODE_SHIFT: begin
                        if (i_valid) begin
                            stage_d[0] = i_data;
                            for (int k = 1; k < LENGTH; k++) begin
                                stage_d[k] = stage_q[k-1];
                            end
                            if (count_q != CNT_FULL) begin
                                count_d = count_q + 1'b1;
                            end
                            valid_d = (count_d == CNT_FULL);
                        end
                    end
                    MODE_LOAD: begin
                        for (int k = 0; k < LENGTH; k++) begin
                            stage_d[k] = i_load[k*WIDTH +: WIDTH];
                        end
                        count_d = CNT_FULL;
                        valid_d = 1'b1;
                    end
                    MODE_ROTATE: begin
                        stage_d[0] = stage_q[LENGTH-1];
                        for (int k = 1; k < LENGTH; k++) begin
                            stage_d[k] = stage_q[k-1];
                        end
                        valid_d = (count_q == CNT_FULL);
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < LENGTH; k++) begin
                stage_q[k] <= '0;
            end
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            stage_q <= stage_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    for (genvar g = 0; g < LENGTH; g++) begin : g_par
        assign o_par[g*WIDTH +: WIDTH] = stage_q[g];
    end

    // Decoded select rather than a direct index so out-of-range taps read zero.
    always_comb begin
        o_tap = '0;
        for (int k = 0; k < LENGTH; k++) begin
            if (TAP_W'(k) == i_tap_sel) begin
                o_tap = stage_q[k];
            end
        end
    end

    assign o_ser   = stage_q[LENGTH-1];
    assign o_count = count_q;
    assign o_full  = (count_q == CNT_FULL);
    assign o_valid = valid_q;

`ifdef SHIFT_WINDOW_SUM_EN
    logic [SUM_W-1:0] load_sum;
    logic             acc_clr;
    logic             acc_load;
    logic             acc_upd;

    always_comb begin
        load_sum = '0;
        for (int k = 0; k < LENGTH; k++) begin
            load_sum = load_sum + SUM_W'(i_load[k*WIDTH +: WIDTH]);
        end
    end

    assign acc_clr  = i_en & i_clr;
    assign acc_load = i_en & ~i_clr & (i_mode == MODE_LOAD);
    assign acc_upd  = i_en & ~i_clr & (i_mode == MODE_SHIFT) & i_valid;

    shift_window_acc #(
        .WIDTH (WIDTH),
        .SUM_W (SUM_W)
    ) u_acc (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (acc_clr),
        .i_load     (acc_load),
        .i_load_val (load_sum),
        .i_upd      (acc_upd),
        .i_add      (i_data),
        .i_sub      (stage_q[LENGTH-1]),
        .o_sum      (o_sum)
    );
`else
    assign o_sum = '0;
`endif

endmodule

// File: tb/tb_shift_window.sv
// tb/tb_shift_window.sv - scoreboard bench for shift_window (WIDTH=8, LENGTH=4)
module tb_shift_window;
    import shift_window_pkg::*;

`ifdef SHIFT_WINDOW_SUM_EN
    localparam bit SUM_ON = 1'b1;
`else
    localparam bit SUM_ON = 1'b0;
`endif

    logic        i_clk;
    logic        i_rst_n;
    logic        i_en;
    logic        i_clr;
    logic [1:0]  i_mode;
    logic        i_valid;
    logic [7:0]  i_data;
    logic [31:0] i_load;
    logic [1:0]  i_tap_sel;
    logic [7:0]  o_ser;
    logic [31:0] o_par;
    logic [7:0]  o_tap;
    logic [2:0]  o_count;
    logic        o_full;
    logic        o_valid;
    logic [9:0]  o_sum;

    shift_window #(.WIDTH(8), .LENGTH(4)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_en      (i_en),
        .i_clr     (i_clr),
        .i_mode    (i_mode),
        .i_valid   (i_valid),
        .i_data    (i_data),
        .i_load    (i_load),
        .i_tap_sel (i_tap_sel),
        .o_ser     (o_ser),
        .o_par     (o_par),
        .o_tap     (o_tap),
        .o_count   (o_count),
        .o_full    (o_full),
        .o_valid   (o_valid),
        .o_sum     (o_sum)
    );

    typedef struct {
        string       nm;
        logic [31:0] par;
        logic [2:0]  cnt;
        logic        vld;
        logic [9:0]  sum;
        logic [7:0]  tap;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    function automatic void chk_all(input exp_t e);
        chk({e.nm, ".par"},   64'(o_par),   64'(e.par));
        chk({e.nm, ".ser"},   64'(o_ser),   64'(e.par[31:24]));
        chk({e.nm, ".tap"},   64'(o_tap),   64'(e.tap));
        chk({e.nm, ".count"}, 64'(o_count), 64'(e.cnt));
        chk({e.nm, ".full"},  64'(o_full),  64'(e.cnt == 3'd4));
        chk({e.nm, ".valid"}, 64'(o_valid), 64'(e.vld));
        chk({e.nm, ".sum"},   64'(o_sum),   SUM_ON ? 64'(e.sum) : 64'd0);
    endfunction

    // Monitor: one expected snapshot per driven cycle, compared just after the edge.
    always @(posedge i_clk) begin
        #1;
        if (q.size() > 0) begin
            chk_all(q.pop_front());
        end
    end

    task automatic step(input string nm, input logic [1:0] mode, input logic en, input logic clr,
                        input logic vld, input logic [7:0] data, input logic [31:0] load,
                        input logic [1:0] tsel, input logic [31:0] epar, input logic [2:0] ecnt,
                        input logic ev, input logic [9:0] esum, input logic [7:0] etap);
        exp_t e;
        i_mode = mode; i_en = en; i_clr = clr; i_valid = vld;
        i_data = data; i_load = load; i_tap_sel = tsel;
        e.nm = nm; e.par = epar; e.cnt = ecnt; e.vld = ev; e.sum = esum; e.tap = etap;
        q.push_back(e);
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    initial begin
        exp_t z;
        z.par = '0; z.cnt = '0; z.vld = 1'b0; z.sum = '0; z.tap = '0;
        i_rst_n = 1'b0; i_en = 1'b0; i_clr = 1'b0; i_mode = MODE_HOLD; i_valid = 1'b0;
        i_data = '0; i_load = '0; i_tap_sel = '0;
        #3;
        z.nm = "reset";
        chk_all(z);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // name, mode, en, clr, vld, data, load, tsel | par, cnt, valid, sum, tap
        step("push11", MODE_SHIFT, 1, 0, 1, 8'h11, 0, 0, 32'h00000011, 1, 0, 10'h011, 8'h11);
        step("push12", MODE_SHIFT, 1, 0, 1, 8'h12, 0, 0, 32'h00001112, 2, 0, 10'h023, 8'h12);
        step("push13", MODE_SHIFT, 1, 0, 1, 8'h13, 0, 0, 32'h00111213, 3, 0, 10'h036, 8'h13);
        step("push14", MODE_SHIFT, 1, 0, 1, 8'h14, 0, 0, 32'h11121314, 4, 1, 10'h04A, 8'h14);
        step("hold1",  MODE_HOLD,  1, 0, 1, 8'h99, 0, 0, 32'h11121314, 4, 0, 10'h04A, 8'h14);
        step("push15", MODE_SHIFT, 1, 0, 1, 8'h15, 0, 0, 32'h12131415, 4, 1, 10'h04E, 8'h15);
        step("rotate", MODE_ROTATE,1, 0, 1, 8'h77, 0, 0, 32'h13141512, 4, 1, 10'h04E, 8'h12);
        step("tap2",   MODE_HOLD,  1, 0, 0, 8'h00, 0, 2, 32'h13141512, 4, 0, 10'h04E, 8'h14);
        step("load",   MODE_LOAD,  1, 0, 0, 8'h00, 32'hFFFFFFFF, 2, 32'hFFFFFFFF, 4, 1, 10'h3FC, 8'hFF);
        step("clrload",MODE_LOAD,  1, 1, 0, 8'h00, 32'hFFFFFFFF, 2, 32'h00000000, 0, 0, 10'h000, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step("novalid", MODE_SHIFT, 1, 0, 0, 8'hAA, 0, 1, 32'h0, 0, 0, 10'h000, 8'h00);
        end
        step("en0",    MODE_SHIFT, 0, 0, 1, 8'h55, 0, 1, 32'h00000000, 0, 0, 10'h000, 8'h00);
        step("part1",  MODE_SHIFT, 1, 0, 1, 8'h21, 0, 1, 32'h00000021, 1, 0, 10'h021, 8'h00);
        step("part2",  MODE_SHIFT, 1, 0, 1, 8'h22, 0, 1, 32'h00002122, 2, 0, 10'h043, 8'h21);
        step("part3",  MODE_SHIFT, 1, 0, 1, 8'h23, 0, 1, 32'h00212223, 3, 0, 10'h066, 8'h22);

        @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        z.nm = "midreset";
        chk_all(z);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step("after",  MODE_SHIFT, 1, 0, 1, 8'h77, 0, 1, 32'h00000077, 1, 0, 10'h077, 8'h00);
        step("idle",   MODE_HOLD,  1, 0, 0, 8'h00, 0, 0, 32'h00000077, 1, 0, 10'h077, 8'h77);

        @(posedge i_clk);
        #2;
        chk("drain", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
